// File: rtl/pc_fetch_unit.sv
// Program counter and instruction register feeding the control FSM: next-PC select
// (jump/branch/sequential), IR capture with a one-cycle memory-latency bypass, and a commit counter.
module pc_fetch_unit #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_enable,
    input  logic              branch_sel,
    input  logic              jump_sel,
    input  logic [3:0]        disp_high,
    input  logic [3:0]        disp_low,
    input  logic [15:0]       jump_target,
    input  logic              latch_enable,
    input  logic [15:0]       mem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [15:0]       instruction,
    output logic [15:0]       link_value,
    output logic [15:0]       retire_count
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              fetch_q, fetch_d;
    logic [15:0]       retire_q, retire_d;

    logic [15:0]       disp_ext;
    logic [ADDR_W-1:0] disp;
    logic [ADDR_W-1:0] pc_inc;

    // 8-bit two's-complement displacement, widened then trimmed to the PC width.
    assign disp_ext = {{8{disp_high[3]}}, disp_high, disp_low};
    assign disp     = disp_ext[ADDR_W-1:0];
    assign pc_inc   = pc_q + ADDR_W'(1);

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        fetch_d  = latch_enable;
        retire_d = retire_q;

        if (fetch_q) begin
            ir_d = mem_rdata;
        end

        if (pc_enable) begin
            retire_d = retire_q + 16'd1;
            if (jump_sel) begin
                pc_d = jump_target[ADDR_W-1:0];
            end else if (branch_sel) begin
                pc_d = pc_q + disp;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            fetch_q  <= 1'b0;
            retire_q <= 16'h0000;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            fetch_q  <= fetch_d;
            retire_q <= retire_d;
        end
    end

    // Decode sees the fetched word in the same cycle the memory returns it.
    assign instruction  = fetch_q ? mem_rdata : ir_q;
    assign pc_out       = pc_q;
    assign link_value   = 16'(pc_inc);
    assign retire_count = retire_q;

endmodule
